// File: rtl/formula_sweep_pkg.sv
// Shared definitions for the formula sweep controller.
//   state_e    : controller states (IDLE, LOAD, SWEEP, FLUSH, DONE)
//   MODE_FIRST : stop at the first falsifying Y assignment
//   MODE_COUNT : sweep every Y assignment and count the falsifying ones
package formula_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SWEEP = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic MODE_FIRST = 1'b0;
   localparam logic MODE_COUNT = 1'b1;

endpackage

// File: rtl/formula_sweep_ctrl_sweep_counter.sv
// Y enumerator and result counters for the formula sweep controller.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart enumeration and zero both counters
//   eval      : an assignment is evaluated this cycle
//   fail      : the evaluated assignment falsified the formula
//   advance   : step Y to the next assignment
//   y         : current Y assignment (drives the formula Y inputs)
//   last      : y is all-ones
//   eval_cnt  : assignments evaluated since clear
//   fail_cnt  : falsifying assignments since clear, saturating at 2^NY
module sweep_counter #(
   parameter int NY = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          eval,
   input  logic          fail,
   input  logic          advance,
   output logic [NY-1:0] y,
   output logic          last,
   output logic [NY:0]   eval_cnt,
   output logic [NY:0]   fail_cnt
);

   localparam logic [NY:0] CNT_MAX = {1'b1, {NY{1'b0}}};

   assign last = &y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y        <= '0;
         eval_cnt <= '0;
         fail_cnt <= '0;
      end else if (clear) begin
         y        <= '0;
         eval_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         // The controller never requests advance on the last assignment,
         // so y cannot wrap past all-ones.
         if (advance)
            y <= y + 1'b1;
         if (eval)
            eval_cnt <= eval_cnt + 1'b1;
         if (fail && (fail_cnt != CNT_MAX))
            fail_cnt <= fail_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/formula_sweep_ctrl.sv
// Sweep controller: latches a fixed X assignment, enumerates every Y
// assignment of an external combinational formula and reports either
// "all satisfied", the first counterexample, or the number of failures.
// Handshake: start is a one-cycle request honoured only when idle (busy=0);
// done pulses for one cycle when results are valid, and results hold until
// the next accepted start.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : run request (IDLE only)
//   count_mode  : sampled with start; 0 = stop at first failure, 1 = count all
//   abort       : ends an active run (LOAD/SWEEP)
//   x_in        : X assignment latched on accepted start
//   f_x, f_y    : registered formula inputs
//   f_o         : formula output, combinational from f_x/f_y
//   busy, done  : run in progress / one-cycle completion pulse
//   all_sat, cex_found, cex_y, aborted, fail_cnt, eval_cnt : results
//   dbg_state   : current controller state
module formula_sweep_ctrl #(
   parameter int NX = 16,
   parameter int NY = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          count_mode,
   input  logic          abort,
   input  logic [NX-1:0] x_in,
   output logic [NX-1:0] f_x,
   output logic [NY-1:0] f_y,
   input  logic          f_o,
   output logic          busy,
   output logic          done,
   output logic          all_sat,
   output logic          cex_found,
   output logic [NY-1:0] cex_y,
   output logic          aborted,
   output logic [NY:0]   fail_cnt,
   output logic [NY:0]   eval_cnt,
   output logic [2:0]    dbg_state
);

   import formula_sweep_pkg::*;

   localparam logic [2:0] IDLE  = ST_IDLE;
   localparam logic [2:0] LOAD  = ST_LOAD;
   localparam logic [2:0] SWEEP = ST_SWEEP;
   localparam logic [2:0] FLUSH = ST_FLUSH;
   localparam logic [2:0] DONE  = ST_DONE;

   logic [2:0] state;
   logic       mode;
   logic       accept;
   logic       eval;
   logic       fail;
   logic       stop_first;
   logic       last;
   logic       advance;

   assign accept     = (state == IDLE) && start;
   // Abort pre-empts evaluation, so a simultaneous failure is not counted.
   assign eval       = (state == SWEEP) && !abort;
   assign fail       = eval && !f_o;
   assign stop_first = fail && (mode == MODE_FIRST);
   assign advance    = eval && !last && !stop_first;

   assign busy      = (state == LOAD) || (state == SWEEP) || (state == FLUSH);
   assign done      = (state == DONE);
   assign dbg_state = state;

   sweep_counter #(.NY(NY)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .eval     (eval),
      .fail     (fail),
      .advance  (advance),
      .y        (f_y),
      .last     (last),
      .eval_cnt (eval_cnt),
      .fail_cnt (fail_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode      <= MODE_FIRST;
         f_x       <= '0;
         cex_y     <= '0;
         cex_found <= 1'b0;
         aborted   <= 1'b0;
         all_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  f_x       <= x_in;
                  mode      <= count_mode;
                  cex_y     <= '0;
                  cex_found <= 1'b0;
                  aborted   <= 1'b0;
                  all_sat   <= 1'b0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               // Settle cycle: f_y is already 0 and the formula output
               // becomes valid for the first evaluation.
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= FLUSH;
               end else begin
                  state <= SWEEP;
               end
            end
            SWEEP: begin
               if (abort) begin
                  aborted <= 1'b1;
                  state   <= FLUSH;
               end else begin
                  if (!f_o && !cex_found) begin
                     cex_y     <= f_y;
                     cex_found <= 1'b1;
                  end
                  if (stop_first || last)
                     state <= FLUSH;
               end
            end
            FLUSH: begin
               all_sat <= !cex_found && !aborted;
               state   <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_formula_sweep_ctrl.sv
// Self-checking bench for formula_sweep_ctrl with NX=2, NY=3 and a
// behavioural formula selected per run.
module tb_formula_sweep_ctrl;

   localparam int NX = 2;
   localparam int NY = 3;

   typedef struct {
      logic          all_sat;
      logic          cex_found;
      logic          aborted;
      logic [NY-1:0] cex_y;
      logic [NY:0]   fail_cnt;
      logic [NY:0]   eval_cnt;
      logic [NX-1:0] f_x;
      int            lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          count_mode = 1'b0;
   logic          abort = 1'b0;
   logic [NX-1:0] x_in = '0;
   logic [NX-1:0] f_x;
   logic [NY-1:0] f_y;
   logic          f_o;
   logic          busy;
   logic          done;
   logic          all_sat;
   logic          cex_found;
   logic [NY-1:0] cex_y;
   logic          aborted;
   logic [NY:0]   fail_cnt;
   logic [NY:0]   eval_cnt;
   logic [2:0]    dbg_state;

   int   formula_sel = 0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   int   start_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural formula ----------------
   function automatic logic formula(input int s, input logic [NY-1:0] y);
      case (s)
         0:       formula = 1'b1;
         1:       formula = (y != 3'd5);
         2:       formula = y[0];
         default: formula = 1'b0;
      endcase
   endfunction

   assign f_o = formula(formula_sel, f_y);

   formula_sweep_ctrl #(.NX(NX), .NY(NY)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .count_mode (count_mode),
      .abort      (abort),
      .x_in       (x_in),
      .f_x        (f_x),
      .f_y        (f_y),
      .f_o        (f_o),
      .busy       (busy),
      .done       (done),
      .all_sat    (all_sat),
      .cex_found  (cex_found),
      .cex_y      (cex_y),
      .aborted    (aborted),
      .fail_cnt   (fail_cnt),
      .eval_cnt   (eval_cnt),
      .dbg_state  (dbg_state)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_f_x"}, f_x, 0);
      check({tag, "_f_y"}, f_y, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_all_sat"}, all_sat, 0);
      check({tag, "_cex_found"}, cex_found, 0);
      check({tag, "_cex_y"}, cex_y, 0);
      check({tag, "_aborted"}, aborted, 0);
      check({tag, "_fail_cnt"}, fail_cnt, 0);
      check({tag, "_eval_cnt"}, eval_cnt, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   function automatic exp_t mk(input logic s, input logic c, input logic a,
                               input int cy, input int fc, input int ec,
                               input int fx, input int lat);
      exp_t e;
      e.all_sat   = s;
      e.cex_found = c;
      e.aborted   = a;
      e.cex_y     = cy[NY-1:0];
      e.fail_cnt  = fc[NY:0];
      e.eval_cnt  = ec[NY:0];
      e.f_x       = fx[NX-1:0];
      e.lat       = lat;
      return e;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            int   s0;
            e  = exp_q.pop_front();
            s0 = start_q.pop_front();
            check("latency", cyc - s0, e.lat);
            check("all_sat", all_sat, e.all_sat);
            check("cex_found", cex_found, e.cex_found);
            check("aborted", aborted, e.aborted);
            check("cex_y", cex_y, e.cex_y);
            check("fail_cnt", fail_cnt, e.fail_cnt);
            check("eval_cnt", eval_cnt, e.eval_cnt);
            check("f_x", f_x, e.f_x);
            check("busy_at_done", busy, 0);
         end
      end
   end

   // ---------------- driver ----------------
   // abort_at / rst_at: cycle offset from the start cycle (0 = unused).
   // A busy-time start with a different x_in is issued two cycles in.
   task automatic run(input int sel, input logic m, input logic [NX-1:0] x,
                      input exp_t e, input int abort_at, input int rst_at);
      int s0;
      int k;
      formula_sel = sel;
      @(negedge clk);
      s0 = cyc;
      if (rst_at == 0) begin
         exp_q.push_back(e);
         start_q.push_back(s0);
      end
      start      = 1'b1;
      count_mode = m;
      x_in       = x;
      @(negedge clk);
      start      = 1'b0;
      count_mode = ~m;
      x_in       = ~x;
      k = 0;
      while (!done && k < 100) begin
         abort = (abort_at != 0) && (cyc == s0 + abort_at);
         start = (cyc == s0 + 2);
         if ((rst_at != 0) && (cyc == s0 + rst_at)) begin
            start = 1'b0;
            rst   = 1'b1;
            #1;
            check_zero("mid_rst");
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         k++;
      end
      abort = 1'b0;
      start = 1'b0;
      if (k >= 100)
         check("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_zero("post_reset");

      // all_sat, fsum, latency 11; x_in=2'b10
      run(0, 1'b0, 2'b10, mk(1, 0, 0, 0, 0, 8, 2, 11), 0, 0);
      // ~(y==5), first mode: stop at y=5
      run(1, 1'b0, 2'b01, mk(0, 1, 0, 5, 1, 6, 1, 9), 0, 0);
      // ~(y==5), count mode
      run(1, 1'b1, 2'b11, mk(0, 1, 0, 5, 1, 8, 3, 11), 0, 0);
      // y[0], count mode: y=0,2,4,6 fail
      run(2, 1'b1, 2'b00, mk(0, 1, 0, 0, 4, 8, 0, 11), 0, 0);
      // constant 0, count mode: every assignment fails, 8 is representable
      run(3, 1'b1, 2'b10, mk(0, 1, 0, 0, 8, 8, 2, 11), 0, 0);
      // constant 0, first mode: stop at k=0
      run(3, 1'b0, 2'b01, mk(0, 1, 0, 0, 1, 1, 1, 4), 0, 0);
      // abort in the third SWEEP cycle
      run(0, 1'b1, 2'b11, mk(0, 0, 1, 0, 0, 2, 3, 6), 4, 0);
      // reset in the middle of SWEEP, then a normal run
      run(0, 1'b1, 2'b10, mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 5);
      check_zero("after_rst");
      run(0, 1'b0, 2'b01, mk(1, 0, 0, 0, 0, 8, 1, 11), 0, 0);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/formula_sweep_ctrl.md
# formula_sweep_ctrl

Sequential controller that checks a combinational Boolean formula block (one output `o_1`, inputs split into fixed X and swept Y variables) by enumerating every Y assignment for a latched X assignment. It drives the formula's inputs, samples its output, and reports one of two results: every assignment satisfied the formula, or the first falsifying Y (counterexample). In count mode it instead reports the total number of falsifying assignments. It sits in the result-checking flow between the test harness and any generated `formula` netlist, which is instantiated outside this block.

## Interface
Parameters:
- `NX`, 16: width of the fixed input vector X (`v_1..v_NX` of the formula).
- `NY`, 15: width of the swept input vector Y; `NX+NY` equals the formula's input count.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `count_mode`  in  1  sampled with `start`. 0 = stop at first counterexample; 1 = full sweep, count failures.
- `abort`  in  1  terminates an active sweep.
- `x_in`  in  NX  fixed assignment, latched on accepted `start`.
- `f_x`  out  NX  to formula X inputs; registered.
- `f_y`  out  NY  to formula Y inputs; registered.
- `f_o`  in  1  formula output; combinational from `f_x`/`f_y`.
- `busy`  out  1  high in LOAD, SWEEP and FLUSH.
- `done`  out  1  one-cycle completion pulse.
- `all_sat`  out  1  no falsifying assignment found in a completed sweep.
- `cex_found`  out  1  at least one falsifying assignment found.
- `cex_y`  out  NY  first falsifying Y.
- `aborted`  out  1  last run ended by `abort`.
- `fail_cnt`  out  NY+1  number of falsifying assignments; saturates at 2^NY.
- `eval_cnt`  out  NY+1  number of assignments evaluated.

## Operation
- Reset: state IDLE. All outputs are 0, including `f_x`, `f_y`, both counters and all flags.
- IDLE:
  - `start`=1 latches `x_in` into `f_x` and `count_mode` into a mode register.
  - Clears `f_y`, `fail_cnt`, `eval_cnt`, `all_sat`, `cex_found`, `aborted` and `cex_y`.
  - Transition to LOAD.
- LOAD: one settle cycle with `f_y`=0, then transition to SWEEP.
- SWEEP: each cycle evaluates the current `f_y` (`f_o` is sampled at the edge).
  - `eval_cnt` increments on every evaluation.
  - If `f_o`=0:
    - `fail_cnt` increments.
    - If `cex_found` was 0, `cex_y` is set to `f_y` and `cex_found` is set.
    - If mode=0, go to FLUSH.
  - If `f_y` is all-ones and the sweep was not already ended above, go to FLUSH.
  - Otherwise `f_y` increments by 1.
  - `f_y` never wraps past all-ones.
- FLUSH: one cycle. Sets `all_sat` = ~`cex_found` & ~`aborted`. Transition to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE. Results hold until the next accepted `start`.
- `abort`:
  - In LOAD or SWEEP: sets `aborted`, goes to FLUSH, and performs no evaluation in that cycle.
  - In other states: ignored.
- If `abort` and `f_o`=0 occur in the same SWEEP cycle, `abort` wins and the failure is not counted.
- `start` outside IDLE is ignored.
- `rst` mid-sweep clears everything immediately. No `done` is produced.

## Timing
- Start-to-done latency:
  - Full sweep: 2^NY + 3 cycles (accepting edge, LOAD, 2^NY evaluations, FLUSH; `done` is high in the following cycle).
  - Early stop on counterexample index k: k+4 cycles.
- Arithmetic:
  - `f_y` is an unsigned NY-bit counter.
  - Counters are NY+1 bits, so that 2^NY is representable.

## Structure
- Package `formula_sweep_pkg`: state enum (IDLE, LOAD, SWEEP, FLUSH, DONE), and mode constants `MODE_FIRST`=0 and `MODE_COUNT`=1.
- A single sub-module `sweep_counter` holds the NY-bit Y enumerator with its last-flag, the `eval_cnt` and the saturating `fail_cnt`. The FSM stays in the top level.

## Test plan
For each scenario the bench attaches a behavioural formula with NX=2 and NY=3.
- Formula = 1 always; start with `x_in`=2'b10 → `f_x`=2'b10. After 11 cycles `done`=1, `all_sat`=1, `eval_cnt`=8, `fail_cnt`=0.
- Formula = ~(y==5), mode 0 → `cex_found`=1, `cex_y`=3'd5, `eval_cnt`=6, `done` 9 cycles after start.
- Same formula, mode 1 → `cex_y`=5, `fail_cnt`=1, `eval_cnt`=8, `all_sat`=0.
- Formula = y[0], mode 1 → `fail_cnt`=4, `cex_y`=0. Formula = 0 → `fail_cnt`=8, with no overflow.
- `abort` during the third SWEEP cycle → `aborted`=1, `eval_cnt`=2, `all_sat`=0, `done` two cycles later. `start` pulses while busy are ignored.
- `rst` asserted mid-SWEEP → all outputs 0 and IDLE immediately. A following start runs normally.
